// File: rtl/exception_unit_pkg.sv
// exception_unit_pkg
//   Shared definitions for the MEM-stage exception unit: MIPS exception
//   codes as presented to CP0, CP0 register addresses used for WB-to-MEM
//   forwarding, and the sequencing FSM state encoding.
package exception_unit_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/exception_unit_cp0_bypass.sv
// exception_unit_cp0_bypass
//   Combinational forwarding of an in-flight WB MTC0 write onto the CP0
//   status, cause and epc values seen by the MEM-stage exception logic.
//   Only the software-writable IP1..IP0 bits (9:8) of cause are forwarded;
//   the rest of cause is owned by hardware and comes from CP0 directly.
// Ports:
//   cp0_status_i/cp0_cause_i/cp0_epc_i  current CP0 register values
//   wb_cp0_we_i/waddr_i/data_i          MTC0 write in WB this cycle
//   status_o/cause_o/epc_o              forwarded values
module exception_unit_cp0_bypass
  import exception_unit_pkg::*;
(
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  always_comb begin
    status_o = cp0_status_i;
    cause_o  = cp0_cause_i;
    epc_o    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_STATUS: status_o = wb_cp0_data_i;
        CP0_CAUSE:  cause_o  = {cp0_cause_i[31:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]};
        CP0_EPC:    epc_o    = wb_cp0_data_i;
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/exception_unit.sv
// exception_unit
//   End-of-MEM exception arbiter. Merges per-instruction exception flags
//   with pending interrupts, picks one code by MIPS priority, hands it to
//   CP0 for exactly one cycle and then holds flush_o for FLUSH_CYCLES
//   cycles while new_pc_o carries the redirect target (EXC_VECTOR, or the
//   forwarded EPC for ERET).
// Build option:
//   EXCEPT_TRAP_EN  when defined, exc_tr_i raises code 0x0d; otherwise the
//                   trap flag is ignored (the port is kept).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_i             MEM held; no exception is taken this cycle
//   inst_valid_i        MEM holds a real instruction
//   pc_i, is_in_delayslot_i, mem_addr_i   MEM instruction context
//   exc_*_i, eret_i     per-instruction exception flags
//   cp0_*_i, wb_cp0_*   CP0 values and WB MTC0 write for forwarding
//   excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o
//                       CP0 update, nonzero only on the first flush cycle
//   flush_o, new_pc_o   pipeline flush and redirect target
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | watching MEM for an exception on an unstalled valid instr
// ST_FLUSH | flush_o high; cnt_q counts remaining flush cycles down to 0
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        exc_if_adel_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_tr_i,
  input  logic        exc_adel_i,
  input  logic        exc_ades_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

`ifdef EXCEPT_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  logic [31:0] status_byp, cause_byp, epc_byp;

  exception_unit_cp0_bypass u_cp0_bypass (
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .status_o       (status_byp),
    .cause_o        (cause_byp),
    .epc_o          (epc_byp)
  );

  // Only IM/IP, IE and EXL take part in interrupt detection.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_byp[31:16], status_byp[7:2],
                             cause_byp[31:16], cause_byp[7:0]};

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] excepttype_q, excepttype_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        delayslot_q, delayslot_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic        int_pending;
  logic        tr_req;
  logic [31:0] code_sel;
  logic [31:0] bad_sel;
  logic        accept;

  always_comb begin
    int_pending = (|(cause_byp[15:8] & status_byp[15:8])) & status_byp[0] & ~status_byp[1];
    tr_req      = exc_tr_i & TRAP_EN;

    code_sel = '0;
    bad_sel  = '0;
    if (int_pending) begin
      code_sel = EXC_INT;
    end else if (exc_if_adel_i) begin
      code_sel = EXC_ADEL;
      bad_sel  = pc_i;
    end else if (exc_ri_i) begin
      code_sel = EXC_RI;
    end else if (exc_ov_i) begin
      code_sel = EXC_OV;
    end else if (exc_sys_i) begin
      code_sel = EXC_SYS;
    end else if (exc_bp_i) begin
      code_sel = EXC_BP;
    end else if (tr_req) begin
      code_sel = EXC_TR;
    end else if (exc_adel_i) begin
      code_sel = EXC_ADEL;
      bad_sel  = mem_addr_i;
    end else if (exc_ades_i) begin
      code_sel = EXC_ADES;
      bad_sel  = mem_addr_i;
    end else if (eret_i) begin
      code_sel = EXC_ERET;
    end

    // Interrupts also need a real instruction to attach to, so the
    // valid gate covers both sources.
    accept = (state_q == ST_IDLE) && inst_valid_i && !stall_i && (code_sel != '0);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    excepttype_d = '0;
    inst_addr_d  = '0;
    delayslot_d  = 1'b0;
    bad_addr_d   = '0;
    new_pc_d     = new_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_FLUSH;
          cnt_d        = CNT_INIT;
          excepttype_d = code_sel;
          inst_addr_d  = pc_i;
          delayslot_d  = is_in_delayslot_i;
          bad_addr_d   = bad_sel;
          new_pc_d     = (code_sel == EXC_ERET) ? epc_byp : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      excepttype_q <= '0;
      inst_addr_q  <= '0;
      delayslot_q  <= 1'b0;
      bad_addr_q   <= '0;
      new_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      excepttype_q <= excepttype_d;
      inst_addr_q  <= inst_addr_d;
      delayslot_q  <= delayslot_d;
      bad_addr_q   <= bad_addr_d;
      new_pc_q     <= new_pc_d;
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = inst_addr_q;
  assign is_in_delayslot_o   = delayslot_q;
  assign bad_addr_o          = bad_addr_q;
  assign flush_o             = (state_q == ST_FLUSH);
  assign new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_exception_unit.sv
module tb_exception_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef EXCEPT_TRAP_EN
  localparam logic [31:0] TR_EXP = 32'h0000_000d;
`else
  localparam logic [31:0] TR_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, inst_valid_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i;
  logic        exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i;
  logic        exc_tr_i, exc_adel_i, exc_ades_i, eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;
  logic [31:0] excepttype_3, current_inst_addr_3, bad_addr_3, new_pc_3;
  logic        is_in_delayslot_3, flush_3;

  int errors = 0;
  int checks = 0;
  int n_type, n_flush;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_if_adel_i(exc_if_adel_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_tr_i(exc_tr_i),
    .exc_adel_i(exc_adel_i), .exc_ades_i(exc_ades_i), .eret_i(eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  exception_unit #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_if_adel_i(exc_if_adel_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_tr_i(exc_tr_i),
    .exc_adel_i(exc_adel_i), .exc_ades_i(exc_ades_i), .eret_i(eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_3), .current_inst_addr_o(current_inst_addr_3),
    .is_in_delayslot_o(is_in_delayslot_3), .bad_addr_o(bad_addr_3),
    .flush_o(flush_3), .new_pc_o(new_pc_3)
  );

  // flags: {if_adel, ri, ov, sys, bp, tr, adel, ades, eret}
  typedef struct {
    logic        valid;
    logic [8:0]  flags;
    logic        ds;
    logic [31:0] pc, mem, status, cause, epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_type, exp_bad, exp_npc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [8:0] f, input logic ds,
                              input logic [31:0] pc, input logic [31:0] mem,
                              input logic [31:0] st, input logic [31:0] ca,
                              input logic [31:0] epc, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] et, input logic [31:0] eb,
                              input logic [31:0] en);
    vec_t r;
    r.valid = v; r.flags = f; r.ds = ds; r.pc = pc; r.mem = mem;
    r.status = st; r.cause = ca; r.epc = epc; r.we = we; r.waddr = wa;
    r.wdata = wd; r.exp_type = et; r.exp_bad = eb; r.exp_npc = en;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i = 0; inst_valid_i = 0; is_in_delayslot_i = 0;
    pc_i = '0; mem_addr_i = '0;
    {exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i,
     exc_tr_i, exc_adel_i, exc_ades_i, eret_i} = '0;
    cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
  endtask

  task automatic drive(input vec_t v);
    stall_i = 0;
    inst_valid_i = v.valid;
    {exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i,
     exc_tr_i, exc_adel_i, exc_ades_i, eret_i} = v.flags;
    is_in_delayslot_i = v.ds; pc_i = v.pc; mem_addr_i = v.mem;
    cp0_status_i = v.status; cp0_cause_i = v.cause; cp0_epc_i = v.epc;
    wb_cp0_we_i = v.we; wb_cp0_waddr_i = v.waddr; wb_cp0_data_i = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic taken;
    taken = (v.exp_type != 0);
    @(negedge clk);
    drive(v);
    @(negedge clk);
    check($sformatf("v%0d type", idx), excepttype_o, v.exp_type);
    check($sformatf("v%0d pc", idx), current_inst_addr_o, taken ? v.pc : 32'h0);
    check($sformatf("v%0d ds", idx), {31'b0, is_in_delayslot_o}, {31'b0, taken & v.ds});
    check($sformatf("v%0d bad", idx), bad_addr_o, v.exp_bad);
    check($sformatf("v%0d flush", idx), {31'b0, flush_o}, {31'b0, taken});
    if (taken) check($sformatf("v%0d newpc", idx), new_pc_o, v.exp_npc);
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;

    //             v  flags          ds  pc            mem           status        cause         epc           we wa      wdata         type   bad           npc
    vecs.push_back(mk(1, 9'b000100000, 0, 32'h80000100, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h08, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b011100000, 0, 32'h80000104, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h0a, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b001110000, 0, 32'h80000108, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h0c, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000110000, 0, 32'h8000010c, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h08, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000011000, 1, 32'h80000110, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h09, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000000110, 0, 32'h80000114, 32'h80000003, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h04, 32'h80000003, VEC));
    vecs.push_back(mk(1, 9'b000000011, 0, 32'h80000118, 32'h80000006, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h05, 32'h80000006, VEC));
    vecs.push_back(mk(1, 9'b110000000, 0, 32'h80000202, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h04, 32'h80000202, VEC));
    vecs.push_back(mk(1, 9'b010000000, 1, 32'h80000120, 32'h0,        32'h00000401, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h01, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b010000000, 0, 32'h80000124, 32'h0,        32'h00000403, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h0a, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000000000, 0, 32'h80000128, 32'h0,        32'h00000400, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h00, 32'h0,        VEC));
    vecs.push_back(mk(0, 9'b000000000, 0, 32'h8000012c, 32'h0,        32'h00000401, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h00, 32'h0,        VEC));
    vecs.push_back(mk(0, 9'b000100000, 0, 32'h80000130, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h00, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000000000, 0, 32'h80000134, 32'h0,        32'h0,        32'h00000400, 32'h0,        1, 5'd12, 32'h00000401, 32'h01, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000000000, 0, 32'h80000138, 32'h0,        32'h00000101, 32'h0,        32'h0,        1, 5'd13, 32'h00000100, 32'h01, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000000000, 0, 32'h8000013c, 32'h0,        32'h00000401, 32'h0,        32'h0,        1, 5'd13, 32'h00000400, 32'h00, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000000001, 0, 32'h80000140, 32'h0,        32'h0,        32'h0,        32'h00001000, 1, 5'd14, 32'h00002000, 32'h0e, 32'h0,        32'h00002000));
    vecs.push_back(mk(1, 9'b000000001, 0, 32'h80000144, 32'h0,        32'h0,        32'h0,        32'h00001000, 0, 5'd0,  32'h0,        32'h0e, 32'h0,        32'h00001000));
    vecs.push_back(mk(1, 9'b000000001, 0, 32'h80000148, 32'h0,        32'h0,        32'h0,        32'h00001000, 1, 5'd12, 32'h00002000, 32'h0e, 32'h0,        32'h00001000));
    vecs.push_back(mk(1, 9'b000001000, 0, 32'h8000014c, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        TR_EXP, 32'h0,        VEC));
    vecs.push_back(mk(1, 9'b000011000, 0, 32'h80000150, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h09, 32'h0,        VEC));

    // reset state
    repeat (2) @(negedge clk);
    check("rst type", excepttype_o, 32'h0);
    check("rst pc", current_inst_addr_o, 32'h0);
    check("rst ds", {31'b0, is_in_delayslot_o}, 32'h0);
    check("rst bad", bad_addr_o, 32'h0);
    check("rst flush", {31'b0, flush_o}, 32'h0);
    check("rst newpc", new_pc_o, 32'h0);
    check("rst flush3", {31'b0, flush_3}, 32'h0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // stalled ADES: nothing taken while stalled, exactly once afterwards
    @(negedge clk);
    inst_valid_i = 1; exc_ades_i = 1; mem_addr_i = 32'h80000003;
    pc_i = 32'h80000400; stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d type", i), excepttype_o, 32'h0);
      check($sformatf("stall%0d flush", i), {31'b0, flush_o}, 32'h0);
    end
    stall_i = 0;
    @(negedge clk);
    check("unstall type", excepttype_o, 32'h05);
    check("unstall bad", bad_addr_o, 32'h80000003);
    check("unstall flush", {31'b0, flush_o}, 32'h1);
    idle_inputs();
    @(negedge clk);
    check("after type", excepttype_o, 32'h0);
    check("after bad", bad_addr_o, 32'h0);
    check("after flush", {31'b0, flush_o}, 32'h0);
    repeat (4) @(negedge clk);

    // FLUSH_CYCLES=3 with BP held through the flush window
    inst_valid_i = 1; exc_bp_i = 1; pc_i = 32'h80000500;
    n_type = 0; n_flush = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (excepttype_3 != 0) n_type++;
      if (flush_3) n_flush++;
      if (i == 0) check("bp3 type", excepttype_3, 32'h09);
      if (i == 2) begin
        check("bp3 newpc held", new_pc_3, VEC);
        check("bp3 type cleared", excepttype_3, 32'h0);
        idle_inputs();
      end
    end
    check("bp3 flush cycles", n_flush, 32'd3);
    check("bp3 type count", n_type, 32'd1);

    // reset asserted mid-flush aborts it
    @(negedge clk);
    inst_valid_i = 1; exc_sys_i = 1; pc_i = 32'h80000600;
    @(negedge clk);
    check("rstflush pre", {31'b0, flush_3}, 32'h1);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    check("rstflush flush3", {31'b0, flush_3}, 32'h0);
    check("rstflush newpc3", new_pc_3, 32'h0);
    check("rstflush type", excepttype_o, 32'h0);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
